// File: rtl/sram_burst_controller_if.sv
// CPU-side request/response bundle for the SRAM burst controller.
// The memory stage drives requests; the controller answers with data and ready.
interface sram_burst_controller_if #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 2
);
  localparam int BB = $clog2(BURST_LEN);
  localparam int IW = (BB > 0) ? BB : 1;

  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [IW-1:0]     rd_word_idx;
  logic              ready;

  modport master (
    output wr_en, rd_en, address, wr_data,
    input  rd_data, rd_valid, rd_word_idx, ready
  );

  modport slave (
    input  wr_en, rd_en, address, wr_data,
    output rd_data, rd_valid, rd_word_idx, ready
  );
endinterface

// File: rtl/sram_burst_controller.sv
// Bridge from the memory stage to a 16-bit async SRAM.
// Single-word writes, aligned burst reads for line fill.
module sram_burst_controller #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int BURST_LEN   = 2
) (
  input  logic               clk,
  input  logic               rst,
  sram_burst_controller_if.slave bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N
);

  localparam int H    = DATA_W / SRAM_DW;
  localparam int HB   = $clog2(H);
  localparam int HW   = (HB > 0) ? HB : 1;
  localparam int BB   = $clog2(BURST_LEN);
  localparam int IW   = (BB > 0) ? BB : 1;
  localparam int WI_W = SRAM_AW - HB;
  localparam int SH   = $clog2(DATA_W / 8);
  localparam int ACB  = $clog2(WAIT_CYCLES + 1);
  localparam int AC_W = (ACB > 0) ? ACB : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t             state_q;
  logic [AC_W-1:0]    acc_q;
  logic [HW-1:0]      half_q;
  logic [IW-1:0]      word_q;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_q;
  logic [DATA_W-1:0]  asm_q;
  logic [DATA_W-1:0]  asm_next;
  logic [WI_W-1:0]    word_idx;
  logic [WI_W-1:0]    burst_start;
  logic [WI_W-1:0]    rd_word;
  logic               acc_last;
  logic               half_last;
  logic               word_last;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_q : {SRAM_DW{1'bz}};

  // Out-of-range addresses simply wrap into the SRAM word space.
  assign word_idx    = WI_W'((bus.address - 32'(BASE_ADDR)) >> SH);
  assign burst_start = word_idx & ~WI_W'(BURST_LEN - 1);
  assign rd_word     = burst_start + WI_W'(word_q);
  assign acc_last    = (acc_q == AC_W'(WAIT_CYCLES));
  assign half_last   = (half_q == HW'(H - 1));
  assign word_last   = (word_q == IW'(BURST_LEN - 1));

  assign bus.ready = (state_q == IDLE) ? ~(bus.wr_en | bus.rd_en)
                                       : (state_q == DONE);

  function automatic logic [SRAM_AW-1:0] sram_addr(
    input logic [WI_W-1:0] w,
    input int unsigned     h
  );
    return (SRAM_AW'(w) << HB) | SRAM_AW'(h);
  endfunction

  // Merge the current SRAM half into the word being assembled.
  always_comb begin
    asm_next = asm_q;
    asm_next[32'(half_q) * SRAM_DW +: SRAM_DW] = SRAM_DQ;
  end

  // Access sequencer: one state machine with registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      half_q          <= '0;
      word_q          <= '0;
      SRAM_WE_N       <= 1'b1;
      SRAM_OE_N       <= 1'b0;
      SRAM_ADDR       <= '0;
      dq_oe           <= 1'b0;
      dq_q            <= '0;
      asm_q           <= '0;
      bus.rd_data     <= '0;
      bus.rd_valid    <= 1'b0;
      bus.rd_word_idx <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.wr_en) begin
            state_q   <= WRITE;
            acc_q     <= '0;
            half_q    <= '0;
            word_q    <= '0;
            SRAM_ADDR <= sram_addr(word_idx, 0);
            SRAM_WE_N <= 1'b0;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b1;
            dq_q      <= bus.wr_data[SRAM_DW-1:0];
          end else if (bus.rd_en) begin
            state_q   <= READ;
            acc_q     <= '0;
            half_q    <= '0;
            word_q    <= '0;
            SRAM_ADDR <= sram_addr(burst_start, 0);
            SRAM_OE_N <= 1'b0;
          end
        end
        WRITE: begin
          if (!acc_last) begin
            acc_q <= acc_q + 1'b1;
          end else begin
            acc_q <= '0;
            if (half_last) begin
              state_q   <= DONE;
              SRAM_WE_N <= 1'b1;
              SRAM_OE_N <= 1'b0;
              dq_oe     <= 1'b0;
            end else begin
              half_q    <= half_q + 1'b1;
              SRAM_ADDR <= sram_addr(word_idx, 32'(half_q) + 32'd1);
              dq_q      <= bus.wr_data[(32'(half_q) + 32'd1) * SRAM_DW
                                       +: SRAM_DW];
            end
          end
        end
        READ: begin
          if (!acc_last) begin
            acc_q <= acc_q + 1'b1;
          end else begin
            acc_q <= '0;
            asm_q <= asm_next;
            if (half_last) begin
              bus.rd_data     <= asm_next;
              bus.rd_valid    <= 1'b1;
              bus.rd_word_idx <= word_q;
              half_q          <= '0;
              if (word_last) begin
                state_q <= DONE;
              end else begin
                word_q    <= word_q + 1'b1;
                SRAM_ADDR <= sram_addr(rd_word + WI_W'(1), 0);
              end
            end else begin
              half_q    <= half_q + 1'b1;
              SRAM_ADDR <= sram_addr(rd_word, 32'(half_q) + 32'd1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
Parametrised bridge between the pipeline memory stage and the external asynchronous 16-bit SRAM. Each CPU word is DATA_W bits and is split into H = DATA_W/SRAM_DW SRAM half-accesses. Each SRAM access lasts WAIT_CYCLES+1 clocks. Writes move a single word. Reads fetch an aligned burst of BURST_LEN words for cache-line fill, and report each word with a valid strobe.

Parameters:
DATA_W, 32, CPU word width; integer multiple of SRAM_DW, with H a power of two
SRAM_DW, 16, SRAM data bus width
SRAM_AW, 18, SRAM address width
BASE_ADDR, 1024, CPU byte address that maps to SRAM word 0
WAIT_CYCLES, 1, extra clocks per SRAM access (>=0); ACC = WAIT_CYCLES+1
BURST_LEN, 2, words per read burst (power of two, >=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request; held until ready
rd_en  in  1  read request; held until ready
address  in  32  CPU byte address
wr_data  in  DATA_W  write word
rd_data  out  DATA_W  most recently assembled read word
rd_valid  out  1  one-cycle strobe: rd_data is valid
rd_word_idx  out  log2(BURST_LEN) (min 1)  index of the rd_data word within the burst
ready  out  1  controller free / operation complete
SRAM_DQ  inout  SRAM_DW  SRAM data
SRAM_ADDR  out  SRAM_AW  SRAM address
SRAM_WE_N  out  1  write enable, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_UB_N, SRAM_LB_N, SRAM_CE_N  out  1 each  tied 0

Behaviour:
- Reset values:
  - state IDLE; all counters 0
  - SRAM_WE_N=1, SRAM_OE_N=0, SRAM_ADDR=0, SRAM_DQ=Z
  - rd_data=0, rd_valid=0, rd_word_idx=0
  - ready = ~(wr_en|rd_en), combinational in IDLE
- Address mapping:
  - word_idx = (address - BASE_ADDR) >> log2(DATA_W/8), truncated to SRAM_AW - log2(H) bits
  - Underflow or overflow wraps modulo; no error is flagged.
  - SRAM_ADDR = {word_idx, half_idx}, half 0 = least significant SRAM_DW bits.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - wr_en=1 -> WRITE. Write has priority when both requests are high.
  - else rd_en=1 -> READ.
  - else stay in IDLE.
  - Counters are cleared on entry to WRITE or READ.
- WRITE:
  - For h = 0..H-1: drive SRAM_ADDR={word_idx,h} and SRAM_DQ=wr_data[h*SRAM_DW +: SRAM_DW], with SRAM_WE_N=0 and SRAM_OE_N=1, for ACC cycles each.
  - After the last cycle -> DONE.
  - Busy time is H*ACC cycles.
- READ:
  - Burst start word = word_idx with its low log2(BURST_LEN) bits cleared.
  - For w = 0..BURST_LEN-1, h = 0..H-1: drive SRAM_ADDR={start+w,h} for ACC cycles.
  - SRAM_DQ is sampled into half h of the assembly register at the last of those ACC cycles.
  - One cycle after a word's last half is sampled: rd_data = that word, rd_valid=1, rd_word_idx=w.
  - After the last half of the last word -> DONE.
  - Busy time is BURST_LEN*H*ACC cycles.
  - The final word's rd_valid coincides with the DONE cycle.
- DONE:
  - ready=1 for exactly one cycle, then -> IDLE unconditionally.
  - The requester must drop or replace its request on the cycle after ready.
- ready=0 in WRITE and READ, and in IDLE whenever a request is present.
- SRAM_DQ is driven only in WRITE; it is Z in all other states.
- rd_data holds its value between strobes and is not cleared by writes.
- Inputs wr_data and address must stay stable until DONE. They are not registered.
- Reset mid-operation:
  - On the next edge, return to IDLE and apply all reset values.
  - Pending rd_valid strobes are cancelled.
  - A partial SRAM write may remain; this is acceptable.

Test Plan:
1. Defaults, write 0xDEADBEEF to 1032 -> SRAM_ADDR=4, DQ=0xBEEF, WE_N=0 for cycles 1-2. Then SRAM_ADDR=5, DQ=0xDEAD for cycles 3-4. ready=1 in cycle 5; OE_N=1 throughout.
2. Defaults, read 1036 after preloading SRAM words 4..7 = 0x1111, 0x2222, 0x3333, 0x4444 -> SRAM_ADDR 4,5,6,7, two cycles each. rd_valid in cycle 5 with idx0, data 0x22221111. rd_valid in cycle 9 with idx1, data 0x44443333. ready in cycle 9.
3. wr_en and rd_en both high in IDLE -> write sequence is performed, no rd_valid is seen; ready=0 in the request cycle.
4. rst asserted in cycle 3 of a read -> next cycle: IDLE, WE_N=1, DQ=Z, SRAM_ADDR=0, no rd_valid. ready follows ~request.
5. WAIT_CYCLES=0, BURST_LEN=1 -> write busy 2 cycles with ready in cycle 3. Read of 1032 gives rd_valid and ready in cycle 3, rd_word_idx=0.
6. Read address 1020 (below BASE_ADDR), BURST_LEN=1 -> word index wraps to 0x1FFFF; SRAM_ADDR=0x3FFFE then 0x3FFFF; completes normally.
